// File: rtl/vga_pixel_feeder.sv
// Pixel FIFO and frame-alignment sequencer that feeds the VGA timing block's color_in.
// Define VGA_FEEDER_STATS_EN to add saturating frame_count / underflow_count outputs.
module vga_pixel_feeder #(
  parameter int          DEPTH_LOG2 = 4,
  parameter int          H_VISIBLE  = 1024,
  parameter int          V_VISIBLE  = 768,
  parameter logic [23:0] FILL_COLOR = 24'h000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [23:0]           s_data,
  input  logic                  s_sof,
  input  logic                  screenend,
  input  logic                  active,
  output logic [23:0]           color_out,
  output logic                  underflow,
  output logic                  sof_err,
`ifdef VGA_FEEDER_STATS_EN
  output logic [15:0]           frame_count,
  output logic [15:0]           underflow_count,
`endif
  output logic [DEPTH_LOG2:0]   level
);

  // state | meaning
  // SYNC  | discard non-sof head entries; hold an sof head until screenend
  // ARMED | sof at head, waiting for the first active cycle
  // RUN   | pop one pixel per active cycle until the frame total is reached
  // DONE  | frame complete, wait for screenend
  // ERR   | underflow seen, drive fill until screenend
  typedef enum logic [2:0] {ST_SYNC, ST_ARMED, ST_RUN, ST_DONE, ST_ERR} state_t;

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam int                  TOTAL    = H_VISIBLE * V_VISIBLE;
  localparam int                  CW       = $clog2(TOTAL) + 1;
  localparam logic [CW-1:0]       LAST     = CW'(TOTAL - 1);
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);

  state_t                state_q, state_d;
  logic [24:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   level_q;
  logic [CW-1:0]         cnt_q;
  logic [23:0]           color_q;
  logic                  underflow_q, sof_err_q;
  logic                  full, empty, push, pop, show;
  logic                  uf_set, serr_set, cnt_clr, cnt_one, cnt_inc;
  logic [24:0]           head;
  logic                  head_sof;

  assign full      = (level_q == FULL_LVL);
  assign empty     = (level_q == '0);
  assign s_ready   = !full;
  assign push      = s_valid && !full;
  assign head      = mem[rd_ptr];
  assign head_sof  = head[24];
  assign level     = level_q;
  assign color_out = color_q;
  assign underflow = underflow_q;
  assign sof_err   = sof_err_q;

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    show     = 1'b0;
    uf_set   = 1'b0;
    serr_set = 1'b0;
    cnt_clr  = 1'b0;
    cnt_one  = 1'b0;
    cnt_inc  = 1'b0;
    case (state_q)
      ST_SYNC: begin
        if (!empty) begin
          if (!head_sof) begin
            pop = 1'b1;
          end else if (screenend) begin
            state_d = ST_ARMED;
            cnt_clr = 1'b1;
          end
        end
      end
      ST_ARMED: begin
        // ARMED is only entered with an sof head, so the else branch is a safety net
        if (active && !empty) begin
          pop = 1'b1;
          if (head_sof) begin
            show    = 1'b1;
            cnt_one = 1'b1;
            state_d = ST_RUN;
          end else begin
            serr_set = 1'b1;
            state_d  = ST_SYNC;
          end
        end
      end
      ST_RUN: begin
        if (active) begin
          if (empty) begin
            uf_set  = 1'b1;
            state_d = ST_ERR;
          end else if (head_sof) begin
            serr_set = 1'b1;
            state_d  = ST_SYNC;
          end else begin
            pop     = 1'b1;
            show    = 1'b1;
            cnt_inc = 1'b1;
            if (cnt_q == LAST) state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (screenend) begin
          if (!empty && head_sof) begin
            state_d = ST_ARMED;
            cnt_clr = 1'b1;
          end else begin
            serr_set = 1'b1;
            state_d  = ST_SYNC;
          end
        end
      end
      ST_ERR: begin
        if (screenend) state_d = ST_SYNC;
      end
      default: state_d = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s_sof, s_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SYNC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      cnt_q       <= '0;
      color_q     <= FILL_COLOR;
      underflow_q <= 1'b0;
      sof_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      underflow_q <= uf_set;
      sof_err_q   <= serr_set;
      color_q     <= show ? head[23:0] : FILL_COLOR;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_one) cnt_q <= CW'(1);
      else if (cnt_inc) cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef VGA_FEEDER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count     <= '0;
      underflow_count <= '0;
    end else begin
      if (state_q == ST_RUN && state_d == ST_DONE && frame_count != 16'hFFFF)
        frame_count <= frame_count + 1'b1;
      if (underflow_q && underflow_count != 16'hFFFF)
        underflow_count <= underflow_count + 1'b1;
    end
  end
`endif

endmodule
